clk_tick_scheduler: RTL and testbench

CLK_TICK_SCHEDULER -- requirements
Module: clk_tick_scheduler

---
 rtl/clk_tick_scheduler.sv | 158 +++++++++++++++
 tb/tb_clk_tick_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_scheduler.sv
// Clock tick scheduler: one shared base-tick prescaler driving NCH programmable tick/clkout channels.
// Optional macro CLK_TICK_SCHED_IMMEDIATE_EN applies a pending configuration on the next clk cycle.
module clk_tick_scheduler #(
    parameter int unsigned FREQ_IN   = 100000000,
    parameter int unsigned FREQ_BASE = 1000,
    parameter int unsigned NCH       = 4,
    parameter int unsigned DIVW      = 16,
    parameter int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    input  logic            cfg_en,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  clkout,
    output logic            busy
);
    localparam int unsigned   PRE      = FREQ_IN / FREQ_BASE;
    localparam int unsigned   PW       = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            base_tick;
    logic [CHW-1:0]  pch_q, pch_d;
    logic [DIVW-1:0] pdiv_q, pdiv_d;
    logic            pen_q, pen_d;
    logic            apply;
    logic            pch_valid;

    logic [NCH-1:0]  en_q, en_d;
    logic [DIVW-1:0] div_q    [NCH];
    logic [DIVW-1:0] div_d    [NCH];
    logic [DIVW-1:0] div_last [NCH];
    logic [DIVW-1:0] cnt_q    [NCH];
    logic [DIVW-1:0] cnt_d    [NCH];
    logic [NCH-1:0]  tick_q, tick_d;
    logic [NCH-1:0]  clkout_q, clkout_d;

    // Free-running prescaler; configuration never touches it.
    always_comb begin
        base_tick = (presc_q == PRE_LAST);
        presc_d   = base_tick ? '0 : presc_q + PW'(1);
    end

    // Configuration FSM: capture in IDLE, apply from PEND.
    always_comb begin
        state_d = state_q;
        pch_d   = pch_q;
        pdiv_d  = pdiv_q;
        pen_d   = pen_q;
        apply   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    state_d = S_PEND;
                    pch_d   = cfg_ch;
                    pdiv_d  = cfg_div;
                    pen_d   = cfg_en;
                end
            end
            S_PEND: begin
`ifdef CLK_TICK_SCHED_IMMEDIATE_EN
                apply = 1'b1;
`else
                apply = base_tick;
`endif
                if (apply) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Out-of-range channel numbers are accepted but never match a channel.
    assign pch_valid = (32'(pch_q) < NCH);

    // A divide value of zero behaves exactly like one.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            div_last[i] = (div_q[i] == '0) ? '0 : div_q[i] - DIVW'(1);
        end
    end

    // Per-channel counters; the applied channel skips a coincident base tick.
    always_comb begin
        for (int i = 0; i < int'(NCH); i++) begin
            en_d[i]     = en_q[i];
            div_d[i]    = div_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            clkout_d[i] = clkout_q[i];
            if (apply && pch_valid && (pch_q == CHW'(i))) begin
                en_d[i]     = pen_q;
                div_d[i]    = pdiv_q;
                cnt_d[i]    = '0;
                clkout_d[i] = 1'b0;
            end else if (!en_q[i]) begin
                cnt_d[i]    = '0;
                clkout_d[i] = 1'b0;
            end else if (base_tick) begin
                if (cnt_q[i] >= div_last[i]) begin
                    cnt_d[i]    = '0;
                    tick_d[i]   = 1'b1;
                    clkout_d[i] = ~clkout_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DIVW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            pch_q    <= '0;
            pdiv_q   <= '0;
            pen_q    <= 1'b0;
            en_q     <= '0;
            tick_q   <= '0;
            clkout_q <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                div_q[i] <= DIVW'(1);
                cnt_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            pch_q    <= pch_d;
            pdiv_q   <= pdiv_d;
            pen_q    <= pen_d;
            en_q     <= en_d;
            tick_q   <= tick_d;
            clkout_q <= clkout_d;
            for (int i = 0; i < int'(NCH); i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // cfg_ready drops combinationally with rst so nothing is accepted during reset.
    assign cfg_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q == S_PEND);
    assign tick      = tick_q;
    assign clkout    = clkout_q;

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// Scoreboard bench for clk_tick_scheduler: per-channel queues of predicted tick/clkout events,
// derived from base-tick arithmetic, consumed by a negedge monitor.
module tb_clk_tick_scheduler;
    localparam int unsigned FREQ_IN   = 1000;
    localparam int unsigned FREQ_BASE = 100;
    localparam int unsigned NCH       = 4;
    localparam int unsigned DIVW      = 16;
    localparam int unsigned CHW       = 3;
    localparam int          PRE       = 10;
    localparam int          HORIZON   = 6000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [CHW-1:0]  cfg_ch = '0;
    logic [DIVW-1:0] cfg_div = '0;
    logic            cfg_en = 1'b0;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  clkout;
    logic            busy;

    clk_tick_scheduler #(
        .FREQ_IN   (FREQ_IN),
        .FREQ_BASE (FREQ_BASE),
        .NCH       (NCH),
        .DIVW      (DIVW),
        .CHW       (CHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .tick      (tick),
        .clkout    (clkout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle t sees the state after t rising edges.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int cyc;
        bit tk;
        bit co;
    } exp_t;

    exp_t expq [NCH][$];
    bit   cur_co [NCH];
    int   pend_from = 0;
    int   pend_to   = -1;
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input int ch, input logic [7:0] act,
                                input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d cycle %0d: got %0h expected %0h", name, ch, cyc, act, exp);
        end
    endfunction

    // First base tick (prescaler at PRE-1) at or after cycle t.
    function automatic int next_base(input int t);
        return t + (PRE - 1 - (t % PRE));
    endfunction

    function automatic int apply_cycle(input int ta);
        int a;
`ifdef CLK_TICK_SCHED_IMMEDIATE_EN
        a = ta + 1;
`else
        a = next_base(ta + 1);
`endif
        return a;
    endfunction

    // Request accepted at the end of cycle ta: predict busy window and channel events.
    function automatic void record(input int ta, input int ch, input int dv, input bit en);
        int   a;
        int   d;
        int   b1;
        int   p;
        exp_t e;
        a         = apply_cycle(ta);
        pend_from = ta + 1;
        pend_to   = a;
        if (ch < int'(NCH)) begin
            while (expq[ch].size() > 0 && expq[ch][expq[ch].size() - 1].cyc > a)
                void'(expq[ch].pop_back());
            e.cyc = a + 1; e.tk = 1'b0; e.co = 1'b0;
            expq[ch].push_back(e);
            if (en) begin
                d  = (dv == 0) ? 1 : dv;
                b1 = next_base(a + 1);
                for (int k = 1; k < HORIZON; k++) begin
                    p = b1 + PRE * (k * d - 1) + 1;
                    if (p > HORIZON) break;
                    e.cyc = p; e.tk = 1'b1; e.co = bit'(k % 2);
                    expq[ch].push_back(e);
                end
            end
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the request until the model says the scheduler is idle; keep leaves cfg_valid high.
    task automatic send(input int ch, input int dv, input bit en, input bit keep);
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_div   = DIVW'(dv);
        cfg_en    = en;
        while (cyc <= pend_to) step(1);
        record(cyc, ch, dv, en);
        step(1);
        if (!keep) cfg_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < int'(NCH); c++) begin
            expq[c].delete();
            cur_co[c] = 1'b0;
        end
        pend_from = 0;
        pend_to   = -1;
    endtask

    task automatic release_reset();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ready_after_reset", -1, 8'(cfg_ready), 8'd1);
        chk("busy_after_reset", -1, 8'(busy), 8'd0);
        chk("tick_after_reset", -1, 8'(tick), 8'd0);
        chk("clkout_after_reset", -1, 8'(clkout), 8'd0);
        step(1);
    endtask

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            int ch;
            int dv;
            bit en;
            gap = int'($urandom_range(0, 40));
            ch  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 7));
            dv  = int'($urandom_range(0, 6));
            en  = ($urandom_range(0, 3) != 0);
            step(gap);
            send(ch, dv, en, 1'b0);
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    bit eb;
                    eb = (cyc >= pend_from) && (cyc <= pend_to);
                    chk("busy", -1, 8'(busy), 8'(eb));
                    chk("cfg_ready", -1, 8'(cfg_ready), 8'(!eb));
                    for (int c = 0; c < int'(NCH); c++) begin
                        logic et;
                        et = 1'b0;
                        if (expq[c].size() > 0 && expq[c][0].cyc == cyc) begin
                            et        = expq[c][0].tk;
                            cur_co[c] = expq[c][0].co;
                            void'(expq[c].pop_front());
                        end
                        chk("tick", c, 8'(tick[c]), 8'(et));
                        chk("clkout", c, 8'(clkout[c]), 8'(cur_co[c]));
                    end
                end
            end
        join_none

        model_reset();
        release_reset();

        // Basic programming, including div=0 and div=1 on separate channels.
        send(0, 3, 1'b1, 1'b0);
        send(1, 0, 1'b1, 1'b0);
        send(2, 2, 1'b1, 1'b0);
        send(3, 1, 1'b1, 1'b0);
        step(200);

        // Reconfigure a running channel while neighbours keep ticking.
        send(0, 5, 1'b1, 1'b0);
        step(150);

        // Request held through PEND with different data.
        send(0, 4, 1'b1, 1'b1);
        send(2, 6, 1'b1, 1'b0);
        step(100);

        // Out-of-range channel changes nothing.
        send(5, 7, 1'b0, 1'b0);
        step(100);

        random_burst(25);
        step(200);

        // Reset asserted while a request is pending: outputs clear without a clock edge.
        cfg_valid = 1'b1;
        cfg_ch    = CHW'(1);
        cfg_div   = DIVW'(1);
        cfg_en    = 1'b1;
        while (cyc <= pend_to) step(1);
        step(1);
        cfg_valid = 1'b0;
        #1;
        chk("busy_before_reset", -1, 8'(busy), 8'd1);
        #1 rst = 1'b1;
        #1;
        chk("busy_in_reset", -1, 8'(busy), 8'd0);
        chk("ready_in_reset", -1, 8'(cfg_ready), 8'd0);
        chk("tick_in_reset", -1, 8'(tick), 8'd0);
        chk("clkout_in_reset", -1, 8'(clkout), 8'd0);
        model_reset();
        release_reset();
        step(100);

        send(1, 2, 1'b1, 1'b0);
        send(3, 0, 1'b1, 1'b0);
        random_burst(10);
        step(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
